// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Tracks validity, honours downstream hold, inserts bubbles on flush or load-use hazards, and counts bubbles.
module id_ex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int MEMREAD_BIT = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [1:0]         wb,
  input  logic [2:0]         mem,
  input  logic [3:0]         ex,
  input  logic [DATA_W-1:0]  pc_4,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  input  logic [DATA_W-1:0]  signExt,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] instr20_16,
  input  logic [RADDR_W-1:0] instr15_11,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               cnt_clr,
  output logic               valid_IDEX,
  output logic [1:0]         wb_IDEX,
  output logic [2:0]         mem_IDEX,
  output logic [1:0]         aluop,
  output logic               alusrc,
  output logic               regdst,
  output logic [DATA_W-1:0]  pc_4_IDEX,
  output logic [DATA_W-1:0]  rs_IDEX,
  output logic [DATA_W-1:0]  rt_IDEX,
  output logic [DATA_W-1:0]  signExt_IDEX,
  output logic [RADDR_W-1:0] rs_addr_IDEX,
  output logic [RADDR_W-1:0] instr20_16_IDEX,
  output logic [RADDR_W-1:0] instr15_11_IDEX,
  output logic               stall_o,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               r_valid;
  logic [1:0]         r_wb;
  logic [2:0]         r_mem;
  logic [3:0]         r_ex;
  logic [DATA_W-1:0]  r_pc_4;
  logic [DATA_W-1:0]  r_rs;
  logic [DATA_W-1:0]  r_rt;
  logic [DATA_W-1:0]  r_sext;
  logic [RADDR_W-1:0] r_rs_addr;
  logic [RADDR_W-1:0] r_rt_addr;
  logic [RADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]   r_cnt;

  logic w_hazard;
  logic w_bubble;
  logic w_cnt_max;

  // A load in EX whose destination is read by the instruction in ID; r0 never creates a dependency.
  assign w_hazard = r_valid & r_mem[MEMREAD_BIT] & (r_rt_addr != '0) & id_valid &
                    ((r_rt_addr == id_rs_addr) | (r_rt_addr == instr20_16));
  assign w_bubble  = flush_i | (~hold_i & w_hazard);
  assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});
  assign stall_o   = (w_hazard & ~flush_i) | hold_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_wb      <= '0;
      r_mem     <= '0;
      r_ex      <= '0;
      r_pc_4    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_sext    <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_bubble) begin
        r_valid   <= 1'b0;
        r_wb      <= '0;
        r_mem     <= '0;
        r_ex      <= '0;
        r_pc_4    <= '0;
        r_rs      <= '0;
        r_rt      <= '0;
        r_sext    <= '0;
        r_rs_addr <= '0;
        r_rt_addr <= '0;
        r_rd_addr <= '0;
      end else if (!hold_i) begin
        // Controls are gated by id_valid so an empty slot can never write state downstream.
        r_valid   <= id_valid;
        r_wb      <= id_valid ? wb  : 2'b00;
        r_mem     <= id_valid ? mem : 3'b000;
        r_ex      <= id_valid ? ex  : 4'b0000;
        r_pc_4    <= pc_4;
        r_rs      <= rs;
        r_rt      <= rt;
        r_sext    <= signExt;
        r_rs_addr <= id_rs_addr;
        r_rt_addr <= instr20_16;
        r_rd_addr <= instr15_11;
      end

      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_bubble && !w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_IDEX      = r_valid;
  assign wb_IDEX         = r_wb;
  assign mem_IDEX        = r_mem;
  assign aluop           = r_ex[3:2];
  assign alusrc          = r_ex[1];
  assign regdst          = r_ex[0];
  assign pc_4_IDEX       = r_pc_4;
  assign rs_IDEX         = r_rs;
  assign rt_IDEX         = r_rt;
  assign signExt_IDEX    = r_sext;
  assign rs_addr_IDEX    = r_rs_addr;
  assign instr20_16_IDEX = r_rt_addr;
  assign instr15_11_IDEX = r_rd_addr;
  assign bubble_cnt      = r_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table, hand-written corner sequences, and random stimulus against a reference model.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [1:0]  wb;
  logic [2:0]  mem;
  logic [3:0]  ex;
  logic [31:0] pc_4, rs, rt, signExt;
  logic [4:0]  id_rs_addr, instr20_16, instr15_11;
  logic        hold_i, flush_i, cnt_clr;

  logic        valid_IDEX;
  logic [1:0]  wb_IDEX;
  logic [2:0]  mem_IDEX;
  logic [1:0]  aluop;
  logic        alusrc, regdst;
  logic [31:0] pc_4_IDEX, rs_IDEX, rt_IDEX, signExt_IDEX;
  logic [4:0]  rs_addr_IDEX, instr20_16_IDEX, instr15_11_IDEX;
  logic        stall_o;
  logic [1:0]  bubble_cnt;

  id_ex_pipe_reg #(.DATA_W(32), .RADDR_W(5), .MEMREAD_BIT(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .wb(wb), .mem(mem), .ex(ex),
    .pc_4(pc_4), .rs(rs), .rt(rt), .signExt(signExt),
    .id_rs_addr(id_rs_addr), .instr20_16(instr20_16), .instr15_11(instr15_11),
    .hold_i(hold_i), .flush_i(flush_i), .cnt_clr(cnt_clr),
    .valid_IDEX(valid_IDEX), .wb_IDEX(wb_IDEX), .mem_IDEX(mem_IDEX),
    .aluop(aluop), .alusrc(alusrc), .regdst(regdst),
    .pc_4_IDEX(pc_4_IDEX), .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX), .signExt_IDEX(signExt_IDEX),
    .rs_addr_IDEX(rs_addr_IDEX), .instr20_16_IDEX(instr20_16_IDEX), .instr15_11_IDEX(instr15_11_IDEX),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference state: what the EX stage should hold, plus the bubble count.
  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] pc, rs, rt, se;
    logic [4:0]  a1, a2, a3;
    logic [1:0]  cnt;
  } st_t;

  st_t m;

  function automatic logic model_hazard(input st_t s);
    return s.v && s.mem[1] && (s.a2 != 5'd0) && id_valid &&
           ((s.a2 == id_rs_addr) || (s.a2 == instr20_16));
  endfunction

  function automatic logic model_stall(input st_t s);
    return (model_hazard(s) && !flush_i) || hold_i;
  endfunction

  function automatic st_t model_next(input st_t s);
    st_t n;
    logic bub;
    bub = flush_i || (!hold_i && model_hazard(s));
    n = s;
    if (bub) begin
      n = '0;
    end else if (!hold_i) begin
      n.v   = id_valid;
      n.wb  = id_valid ? wb  : 2'b00;
      n.mem = id_valid ? mem : 3'b000;
      n.ex  = id_valid ? ex  : 4'b0000;
      n.pc = pc_4; n.rs = rs; n.rt = rt; n.se = signExt;
      n.a1 = id_rs_addr; n.a2 = instr20_16; n.a3 = instr15_11;
    end
    if (cnt_clr) n.cnt = 2'd0;
    else if (bub && s.cnt != 2'd3) n.cnt = s.cnt + 2'd1;
    else n.cnt = s.cnt;
    return n;
  endfunction

  task automatic check_state(input st_t e);
    chk("valid", 160'(valid_IDEX), 160'(e.v));
    chk("ctrl", 160'({wb_IDEX, mem_IDEX, aluop, alusrc, regdst}), 160'({e.wb, e.mem, e.ex}));
    chk("data", {pc_4_IDEX, rs_IDEX, rt_IDEX, signExt_IDEX, 32'h0}, {e.pc, e.rs, e.rt, e.se, 32'h0});
    chk("addr", 160'({rs_addr_IDEX, instr20_16_IDEX, instr15_11_IDEX}), 160'({e.a1, e.a2, e.a3}));
    chk("cnt", 160'(bubble_cnt), 160'(e.cnt));
  endtask

  // Called just after a negedge with inputs already set.
  task automatic step();
    st_t e;
    #1 chk("stall", 160'(stall_o), 160'(model_stall(m)));
    e = model_next(m);
    @(posedge clk);
    #1 m = e;
    check_state(m);
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; wb = 2'b00; mem = 3'b000; ex = 4'b0000;
    pc_4 = 32'h0; rs = 32'h0; rt = 32'h0; signExt = 32'h0;
    id_rs_addr = 5'd0; instr20_16 = 5'd0; instr15_11 = 5'd0;
    hold_i = 1'b0; flush_i = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 m = '0;
    check_state(m);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        vin, hold, flush, clr;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] rsd;
    logic [4:0]  a1, a2;
    logic        e_stall, e_valid;
    logic [1:0]  e_aluop;
    logic        e_alusrc, e_regdst;
    logic [2:0]  e_mem;
    logic [31:0] e_rs;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000,4'b1011,32'hDEADBEEF,5'd0,5'd0, 1'b0, 1'b1,2'b10,1'b1,1'b1,3'b000,32'hDEADBEEF,2'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 3'b010,4'b0000,32'h1,5'd3,5'd8,         1'b0, 1'b1,2'b00,1'b0,1'b0,3'b010,32'h1,2'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000,4'b0100,32'h2,5'd8,5'd9,         1'b1, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h0,2'd1};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000,4'b0100,32'h2,5'd8,5'd9,         1'b0, 1'b1,2'b01,1'b0,1'b0,3'b000,32'h2,2'd1};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 3'b010,4'b0000,32'h3,5'd0,5'd0,         1'b0, 1'b1,2'b00,1'b0,1'b0,3'b010,32'h3,2'd1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000,4'b0000,32'h4,5'd0,5'd0,         1'b0, 1'b1,2'b00,1'b0,1'b0,3'b000,32'h4,2'd1};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000,4'b0000,32'h5,5'd0,5'd7,         1'b0, 1'b1,2'b00,1'b0,1'b0,3'b000,32'h5,2'd1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0, 3'b000,4'b0000,32'h6,5'd7,5'd1,         1'b0, 1'b1,2'b00,1'b0,1'b0,3'b000,32'h6,2'd1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0, 3'b111,4'b1111,32'h9,5'd0,5'd0,         1'b0, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h9,2'd1};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 3'b000,4'b1011,32'hA,5'd0,5'd0,         1'b1, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h9,2'd1};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b0, 3'b010,4'b0111,32'hD,5'd2,5'd4,         1'b1, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h9,2'd1};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0, 3'b001,4'b1100,32'hE,5'd5,5'd6,         1'b1, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h9,2'd1};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b0, 3'b000,4'b1011,32'hB,5'd0,5'd0,         1'b1, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h0,2'd2};
    tbl[13] = '{1'b1,1'b0,1'b1,1'b1, 3'b000,4'b1011,32'hC,5'd0,5'd0,         1'b0, 1'b0,2'b00,1'b0,1'b0,3'b000,32'h0,2'd0};

    rst_n = 1'b0;
    clear_inputs();

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      id_valid = tbl[i].vin; hold_i = tbl[i].hold; flush_i = tbl[i].flush; cnt_clr = tbl[i].clr;
      wb = 2'b11; mem = tbl[i].mem; ex = tbl[i].ex; rs = tbl[i].rsd;
      id_rs_addr = tbl[i].a1; instr20_16 = tbl[i].a2;
      #1 chk($sformatf("tbl%0d_stall", i), 160'(stall_o), 160'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 160'(valid_IDEX), 160'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ex", i), 160'({aluop, alusrc, regdst}),
          160'({tbl[i].e_aluop, tbl[i].e_alusrc, tbl[i].e_regdst}));
      chk($sformatf("tbl%0d_mem", i), 160'(mem_IDEX), 160'(tbl[i].e_mem));
      chk($sformatf("tbl%0d_rs", i), 160'(rs_IDEX), 160'(tbl[i].e_rs));
      chk($sformatf("tbl%0d_cnt", i), 160'(bubble_cnt), 160'(tbl[i].e_cnt));
    end

    // Six consecutive flushes saturate a 2-bit counter at 3.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      id_valid = 1'b1; flush_i = 1'b1; rs = 32'h100 + 32'(i);
      step();
      if (i == 2) chk("sat_reach", 160'(bubble_cnt), 160'(2'd3));
    end
    chk("sat_hold", 160'(bubble_cnt), 160'(2'd3));

    // Clear with flush, two more flushes, then a real instruction: valid=1, cnt=2.
    @(negedge clk); cnt_clr = 1'b1; step();
    chk("clr_wins", 160'(bubble_cnt), 160'(2'd0));
    @(negedge clk); cnt_clr = 1'b0; step();
    @(negedge clk); step();
    @(negedge clk);
    flush_i = 1'b0; mem = 3'b010; instr20_16 = 5'd8; ex = 4'b1010; rs = 32'h5A5A5A5A;
    step();
    chk("pre_rst_valid", 160'(valid_IDEX), 160'(1'b1));
    chk("pre_rst_cnt", 160'(bubble_cnt), 160'(2'd2));

    // Asynchronous reset between edges while a load occupies EX and ID would hazard on it.
    #2;
    id_rs_addr = 5'd8; hold_i = 1'b0;
    #1 chk("pre_rst_stall", 160'(stall_o), 160'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 160'(valid_IDEX), 160'(1'b0));
    chk("arst_cnt", 160'(bubble_cnt), 160'(2'd0));
    chk("arst_rs", 160'(rs_IDEX), 160'(32'h0));
    chk("arst_stall_nohold", 160'(stall_o), 160'(1'b0));
    hold_i = 1'b1;
    #1 chk("arst_stall_hold", 160'(stall_o), 160'(1'b1));
    m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();

    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      id_valid   = ($urandom_range(0, 3) != 0);
      hold_i     = ($urandom_range(0, 7) == 0);
      flush_i    = ($urandom_range(0, 9) == 0);
      cnt_clr    = ($urandom_range(0, 29) == 0);
      wb         = 2'($urandom);
      mem        = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom);
      ex         = 4'($urandom);
      pc_4       = $urandom;
      rs         = $urandom;
      rt         = $urandom;
      signExt    = $urandom;
      id_rs_addr = 5'($urandom_range(0, 3));
      instr20_16 = 5'($urandom_range(0, 3));
      instr15_11 = 5'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the pipelined MIPS core, sitting between decode and execute.
- Adds the following on top of a plain register stage:
  - valid tracking
  - downstream hold (stall)
  - flush/bubble insertion
  - integrated load-use hazard detection driving stall_o back to PC/IF_ID
  - saturating bubble counter for performance analysis

Parameters:
- DATA_W, 32, width of pc_4, rs, rt, signExt data paths.
- RADDR_W, 5, register index width.
- MEMREAD_BIT, 1, index within mem control field that is the memory-read (load) flag.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- wb  in  2  write-back controls.
- mem  in  3  memory controls.
- ex  in  4  execute controls: [3:2] aluop, [1] alusrc, [0] regdst.
- pc_4  in  DATA_W  PC+4.
- rs  in  DATA_W  register-file read data A.
- rt  in  DATA_W  register-file read data B.
- signExt  in  DATA_W  sign-extended immediate.
- id_rs_addr  in  RADDR_W  instr[25:21].
- instr20_16  in  RADDR_W  instr[20:16].
- instr15_11  in  RADDR_W  instr[15:11].
- hold_i  in  1  downstream stall; freeze this register.
- flush_i  in  1  squash ID instruction (branch/jump redirect).
- cnt_clr  in  1  synchronous clear of bubble counter.
- valid_IDEX  out  1  EX stage holds a real instruction.
- wb_IDEX  out  2.
- mem_IDEX  out  3.
- aluop  out  2.
- alusrc  out  1.
- regdst  out  1.
- pc_4_IDEX, rs_IDEX, rt_IDEX, signExt_IDEX  out  DATA_W each.
- rs_addr_IDEX, instr20_16_IDEX, instr15_11_IDEX  out  RADDR_W each.
- stall_o  out  1  freeze PC and IF/ID (combinational).
- bubble_cnt  out  CNT_W  bubbles inserted since reset/clear.

Behaviour:
- Reset (rst_n=0, async): every registered output is 0, including valid_IDEX and bubble_cnt. Release is synchronous to the next clk edge.
- hazard, combinational: valid_IDEX & mem_IDEX[MEMREAD_BIT] & (instr20_16_IDEX != 0) & id_valid & (instr20_16_IDEX == id_rs_addr | instr20_16_IDEX == instr20_16).
- stall_o = (hazard & ~flush_i) | hold_i.
- Per-edge update, priority highest first:
  1. flush_i=1: load a bubble. valid_IDEX=0; wb_IDEX, mem_IDEX, aluop, alusrc, regdst all 0; data and address fields also 0. Flush overrides hold_i.
  2. hold_i=1: all pipeline outputs keep their value.
  3. hazard=1: load a bubble, as in 1.
  4. Otherwise, load inputs with 1-cycle latency:
     - valid_IDEX <= id_valid.
     - Control fields load when id_valid=1 and are forced to 0 when id_valid=0.
     - Data fields load unconditionally.
- Load-use stall lasts exactly one cycle. After the bubble the load has left EX, so hazard drops and the held ID instruction proceeds.
- A load writing register 0 never stalls.
- bubble_cnt:
  - Increments by 1 on each edge where a bubble is loaded by case 1 or case 3.
  - Bubbles from id_valid=0 are not counted.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces 0 on that edge and takes priority over increment.
  - Unaffected by hold_i except that case 2 suppresses case 3.
- Reset asserted mid-stall clears everything immediately. stall_o then reads hold_i only, because valid_IDEX=0.
- No combinational path from data inputs to data outputs.

Test Plan:
- Reset and normal pass-through: rst_n=0 → all outputs 0. Release, then id_valid=1, ex=4'b1011, rs=32'hDEADBEEF → one edge later aluop=2'b10, alusrc=1, regdst=1, rs_IDEX=32'hDEADBEEF, valid_IDEX=1.
- Load-use hazard: EX holds load (mem=3'b010, instr20_16=5'd8). ID presents id_rs_addr=8 → stall_o=1 same cycle; next edge valid_IDEX=0, controls 0, bubble_cnt=1. Following cycle stall_o=0 and the ID instruction loads.
- No false hazard: EX load with instr20_16=0 and id_rs_addr=0 → stall_o=0. Non-load EX (mem=0) with matching index → stall_o=0.
- Hold vs flush: hold_i=1 for 3 cycles with changing inputs → outputs constant, stall_o=1. Then hold_i=1 and flush_i=1 together → bubble loaded, bubble_cnt increments.
- Counter: CNT_W=2, six consecutive flushes → bubble_cnt reaches 3 and stays at 3. cnt_clr=1 together with flush → bubble_cnt=0.
- Async reset mid-operation: assert rst_n=0 between clock edges while valid_IDEX=1 and bubble_cnt=2 → outputs 0 immediately, without waiting for clk.
